// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types, geometry constants and helpers for the 4x4
//               matrix keypad scanner: FSM state enum, row/column/code widths,
//               row-drive rotation and row-drive to row-index conversion.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = 4;
  localparam int ROW_W  = 2;
  localparam int COL_W  = 2;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    ACCEPT   = 2'd2,
    HELD     = 2'd3
  } state_e;

  // Active-low one-cold row drive: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  function automatic logic [ROWS-1:0] row_rotate(input logic [ROWS-1:0] row_drv_n);
    return {row_drv_n[ROWS-2:0], row_drv_n[ROWS-1]};
  endfunction

  // Index of the (single) low bit of an active-low row drive.
  function automatic logic [ROW_W-1:0] row_index(input logic [ROWS-1:0] row_drv_n);
    logic [ROW_W-1:0] idx;
    idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!row_drv_n[r]) idx = ROW_W'(r);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick.sv
`default_nettype none
// ============================================================================
// Module      : scan_tick
// Description : Free-running divider counting 0..SCAN_DIV-1; tick is high for
//               the single cycle in which the count sits at its terminal value.
//               Shared with the display digit multiplexer.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset (count returns to 0)
//               tick  - one-cycle pulse every SCAN_DIV cycles
// Revision    : 1.0 - initial release
// ============================================================================
module scan_tick #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int              CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == TERM);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner. Drives one row low at a time,
//               double-flop synchronizes the columns, debounces press and
//               release, and reports row*4+col with a one-cycle strobe.
// Ports       : clk       - system clock
//               rst_n     - asynchronous active-low reset
//               row_n     - row drive, active-low, one bit low at all times
//               col_n     - column sense, active-low, asynchronous to clk
//               key_code  - code of the last accepted key
//               key_valid - one-cycle strobe when key_code is updated
//               key_held  - high while the accepted key remains pressed
// Options     : KEYPAD_REPEAT_EN - auto-repeat strobes while a key is held
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROWS-1:0]   row_n,
  input  logic [COLS-1:0]   col_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_CNT);

  logic tick;

  scan_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Column synchronizer; idle (released) level is all ones.
  logic [COLS-1:0] col_meta_q;
  logic [COLS-1:0] col_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= '1;
      col_s_q    <= '1;
    end else begin
      col_meta_q <= col_n;
      col_s_q    <= col_meta_q;
    end
  end

  state_e            state_q,     state_d;
  logic [ROWS-1:0]   row_n_q,     row_n_d;
  logic [COL_W-1:0]  col_idx_q,   col_idx_d;
  logic [3:0]        cnt_q,       cnt_d;
  logic [CODE_W-1:0] key_code_q,  key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q,  key_held_d;

  logic              any_low;
  logic [COL_W-1:0]  hit_col;
  logic              col_low;
  logic [3:0]        cnt_inc;

`ifdef KEYPAD_REPEAT_EN
  localparam int             RPT_W      = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [RPT_W-1:0] RPT_MAX    = '1;

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic [RPT_W-1:0] rpt_inc;
`else
  logic unused_repeat_params;
  assign unused_repeat_params = (REPEAT_DELAY > REPEAT_RATE);
`endif

  always_comb begin
    any_low = ~&col_s_q;
    // Scan from the top down so the lowest-index low column wins.
    hit_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_s_q[c]) hit_col = COL_W'(c);
    end
    col_low = ~col_s_q[col_idx_q];
    cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  end

  always_comb begin
    state_d     = state_q;
    row_n_d     = row_n_q;
    col_idx_d   = col_idx_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_d       = rpt_q;
    rpt_inc     = (rpt_q == RPT_MAX) ? rpt_q : rpt_q + RPT_W'(1);
`endif

    unique case (state_q)
      SCAN: begin
        if (tick) begin
          if (any_low) begin
            col_idx_d = hit_col;
            cnt_d     = 4'd1;
            state_d   = (DEBOUNCE_CNT == 1) ? ACCEPT : DEBOUNCE;
          end else begin
            row_n_d = row_rotate(row_n_q);
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (col_low) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_TARGET) state_d = ACCEPT;
          end else begin
            cnt_d   = 4'd0;
            row_n_d = row_rotate(row_n_q);
            state_d = SCAN;
          end
        end
      end

      ACCEPT: begin
        key_code_d  = {row_index(row_n_q), col_idx_q};
        key_valid_d = 1'b1;
        key_held_d  = 1'b1;
        cnt_d       = 4'd0;  // reused as the release counter in HELD
`ifdef KEYPAD_REPEAT_EN
        rpt_d       = '0;
`endif
        state_d     = HELD;
      end

      HELD: begin
        // Only the accepted key's column is observed; other keys are ignored.
        if (tick) begin
          if (!col_low) begin
            cnt_d = cnt_inc;
`ifdef KEYPAD_REPEAT_EN
            rpt_d = '0;
`endif
            if (cnt_inc >= DB_TARGET) begin
              cnt_d      = 4'd0;
              key_held_d = 1'b0;
              row_n_d    = row_rotate(row_n_q);
              state_d    = SCAN;
            end
          end else begin
            cnt_d = 4'd0;
`ifdef KEYPAD_REPEAT_EN
            if (rpt_inc == RPT_FIRE) begin
              key_valid_d = 1'b1;
              rpt_d       = RPT_RELOAD;
            end else begin
              rpt_d = rpt_inc;
            end
`endif
          end
        end
      end

      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      row_n_q     <= 4'b1110;
      col_idx_q   <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_n_q     <= row_n_d;
      col_idx_q   <= col_idx_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rpt_q <= '0;
    else        rpt_q <= rpt_d;
  end
`endif

  assign row_n     = row_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner with SCAN_DIV=4 and
//               DEBOUNCE_CNT=3. A behavioural 4x4 keypad turns the set of
//               pressed keys and the row drive into column levels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_DELAY = 5;
  localparam int REPEAT_RATE  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [15:0] pressed = '0;

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Strobe monitor.
  int         cyc = 0;
  int         valid_cnt = 0;
  int         valid_cyc [0:31];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (key_valid) begin
      valid_cnt <= valid_cnt + 1;
      if (valid_cnt < 32) valid_cyc[valid_cnt] <= cyc;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected within [%0d,%0d]", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int base, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step(1);
      if (valid_cnt > base) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_held_low(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step(1);
      if (!key_held) begin
        n = i;
        break;
      end
    end
  endtask

  // Returns just after the row drive switches to 'target'.
  task automatic wait_row_entry(input logic [3:0] target, output bit ok);
    logic [3:0] p;
    ok = 1'b0;
    p  = row_n;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (row_n === target && p !== target) begin
        ok = 1'b1;
        break;
      end
      p = row_n;
    end
  endtask

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
    logic [3:0]  row_after;
  } vec_t;

  vec_t vecs [0:6];

  initial begin
    int         n;
    int         base;
    bit         ok;
    logic [3:0] prev;
    int         last_change;
    int         changes;
    int         bad_order;
    int         bad_gap;

    vecs[0] = '{16'h0200, 4'd9,  4'b0111};  // row 2 col 1
    vecs[1] = '{16'h0001, 4'd0,  4'b1101};  // row 0 col 0
    vecs[2] = '{16'h8000, 4'd15, 4'b1110};  // row 3 col 3
    vecs[3] = '{16'h0040, 4'd6,  4'b1011};  // row 1 col 2
    vecs[4] = '{16'h0050, 4'd4,  4'b1011};  // row 1 cols 0 and 2
    vecs[5] = '{16'h1000, 4'd12, 4'b1110};  // row 3 col 0
    vecs[6] = '{16'h0800, 4'd11, 4'b0111};  // row 2 col 3

    // Reset values, held in and out of reset.
    step(3);
    check("rst_row_n", int'(row_n), 4'b1110);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_held", int'(key_held), 0);
    rst_n = 1'b1;

    // Idle scan: rotation order and a fresh row every SCAN_DIV cycles.
    prev = row_n; last_change = -1; changes = 0; bad_order = 0; bad_gap = 0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (row_n !== prev) begin
        if (row_n !== {prev[2:0], prev[3]}) bad_order++;
        if (last_change >= 0 && (i - last_change) != SCAN_DIV) bad_gap++;
        last_change = i;
        changes++;
        prev = row_n;
      end
    end
    check("idle_order", bad_order, 0);
    check("idle_gap", bad_gap, 0);
    check("idle_changes", changes, 16);
    check("idle_no_valid", valid_cnt, 0);

    // Table of single stable presses.
    for (int v = 0; v < 7; v++) begin
      base    = valid_cnt;
      pressed = vecs[v].keys;
      wait_valid(base, 100, n);
      check("press_seen", int'(n > 0), 1);
      step(12);
      check("one_strobe", valid_cnt - base, 1);
      check("key_code", int'(key_code), int'(vecs[v].code));
      check("held_on", int'(key_held), 1);
      pressed = '0;
      wait_held_low(40, n);
      check_range("release_time", n, 11, 14);
      check("row_after", int'(row_n), int'(vecs[v].row_after));
      step(8);
      check("code_kept", int'(key_code), int'(vecs[v].code));
    end

    // Second key while held is ignored.
    base    = valid_cnt;
    pressed = 16'h0010;
    wait_valid(base, 100, n);
    check("first_key_seen", int'(n > 0), 1);
    pressed = 16'h8010;
    step(12);
    check("second_ignored_cnt", valid_cnt - base, 1);
    check("second_ignored_code", int'(key_code), 4);
    check("second_ignored_row", int'(row_n), 4'b1101);
    check("second_ignored_held", int'(key_held), 1);
    pressed = '0;
    wait_held_low(40, n);
    check("second_release", int'(n > 0), 1);
    step(8);

    // Bounce: two isolated single low samples on row 0 col 3.
    base = valid_cnt;
    for (int g = 0; g < 2; g++) begin
      wait_row_entry(4'b1110, ok);
      check("bounce_row0", int'(ok), 1);
      pressed[3] = 1'b1;
      step(4);
      pressed[3] = 1'b0;
      step(1);
    end
    step(20);
    check("bounce_no_valid", valid_cnt - base, 0);
    check("bounce_no_held", int'(key_held), 0);
    pressed = 16'h0008;
    wait_valid(base, 100, n);
    check("bounce_then_stable", int'(n > 0), 1);
    check("bounce_code", int'(key_code), 3);
    step(4);
    pressed = '0;
    wait_held_low(40, n);
    check("bounce_release", int'(n > 0), 1);
    step(8);

    // Reset during DEBOUNCE on row 2.
    wait_row_entry(4'b1011, ok);
    check("rst_row2", int'(ok), 1);
    pressed = 16'h0200;
    step(5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_row_n", int'(row_n), 4'b1110);
    check("mid_rst_valid", int'(key_valid), 0);
    check("mid_rst_held", int'(key_held), 0);
    check("mid_rst_code", int'(key_code), 0);
    step(2);
    base  = valid_cnt;
    rst_n = 1'b1;
    wait_valid(base, 100, n);
    check_range("redetect_latency", n, 20, 22);
    check("redetect_code", int'(key_code), 9);
    step(4);
    pressed = '0;
    wait_held_low(40, n);
    check("redetect_release", int'(n > 0), 1);
    step(8);

    // Long hold: auto-repeat cadence when enabled, a single strobe otherwise.
    base    = valid_cnt;
    pressed = 16'h8000;
    wait_valid(base, 100, n);
    check("long_seen", int'(n > 0), 1);
    step(60);
    pressed = '0;
    wait_held_low(40, n);
    check("long_release", int'(n > 0), 1);
    step(4);
    check("long_code", int'(key_code), 15);
`ifdef KEYPAD_REPEAT_EN
    check("repeat_count", valid_cnt - base, 7);
    check_range("repeat_first_gap", valid_cyc[base+1] - valid_cyc[base], 19, 20);
    for (int k = 2; k < 7; k++) begin
      check("repeat_gap", valid_cyc[base+k] - valid_cyc[base+k-1], 2 * SCAN_DIV);
    end
`else
    check("no_repeat_count", valid_cnt - base, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
